// File: rtl/conv2d_read_fetcher.sv
// DMem read-address generator and credit-protected response FIFO for the conv2D unit.
// Issues all weight words, then every non-halo IFM word of every window in OFM order.
module conv2d_read_fetcher #(
  parameter int AWIDTH     = 32,
  parameter int DWIDTH     = 32,
  parameter int WT_DIM     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              idle,
  input  logic [31:0]       fm_dim,
  input  logic [AWIDTH-1:0] wt_base_addr,
  input  logic [AWIDTH-1:0] ifm_base_addr,
  output logic [AWIDTH-1:0] req_addr,
  output logic              req_valid,
  input  logic              req_ready,
  input  logic [DWIDTH-1:0] resp_data,
  input  logic              resp_valid,
  output logic [DWIDTH-1:0] rdata,
  output logic              rdata_valid,
  input  logic              rdata_ready
);

  localparam int HALF   = WT_DIM / 2;
  localparam int WT_NUM = WT_DIM * WT_DIM;
  localparam int KW     = $clog2(WT_NUM + 1);
  localparam int MW     = $clog2(WT_DIM + 1);
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, FETCH_WT, FETCH_FM, DRAIN} state_t;

  state_t            state, state_n;
  logic [31:0]       fm_dim_q;
  logic [AWIDTH-1:0] wt_base_q, ifm_base_q;

  logic [KW-1:0]     wt_k;
  logic [31:0]       y, x;
  logic [MW-1:0]     m, n;

  logic [CW-1:0]     outstanding, count;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DWIDTH-1:0] mem [FIFO_DEPTH];

  logic              clr_cnt, wt_step, fm_step;
  logic              req_fire, push, pop, credit_ok;
  logic              wt_last, fm_last, halo;
  logic [31:0]       idx_u, idy_u, fm_off;

  // Window offsets as 32-bit two's complement; bit 31 marks a negative coordinate.
  assign idx_u   = x - 32'(HALF) + 32'(n);
  assign idy_u   = y - 32'(HALF) + 32'(m);
  assign halo    = idx_u[31] || idy_u[31] || (idx_u >= fm_dim_q) || (idy_u >= fm_dim_q);
  assign fm_off  = idy_u * fm_dim_q + idx_u;

  assign wt_last = (wt_k == KW'(WT_NUM - 1));
  assign fm_last = (y == fm_dim_q - 32'd1) && (x == fm_dim_q - 32'd1) &&
                   (m == MW'(WT_DIM - 1)) && (n == MW'(WT_DIM - 1));

  assign credit_ok   = ({1'b0, outstanding} + {1'b0, count}) < (CW + 1)'(FIFO_DEPTH);
  assign req_fire    = req_valid && req_ready;
  assign push        = resp_valid;
  assign rdata_valid = (count != '0);
  assign pop         = rdata_valid && rdata_ready;
  assign rdata       = rdata_valid ? mem[rd_ptr] : '0;
  assign idle        = (state == IDLE);

  always_comb begin
    state_n   = state;
    clr_cnt   = 1'b0;
    wt_step   = 1'b0;
    fm_step   = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FETCH_WT;
          clr_cnt = 1'b1;
        end
      end
      FETCH_WT: begin
        req_valid = credit_ok;
        req_addr  = wt_base_q + AWIDTH'(wt_k);
        if (req_fire) begin
          wt_step = 1'b1;
          if (wt_last) state_n = (fm_dim_q == 32'd0) ? DRAIN : FETCH_FM;
        end
      end
      FETCH_FM: begin
        req_valid = credit_ok && !halo;
        req_addr  = ifm_base_q + AWIDTH'(fm_off);
        // Halo cells advance unconditionally; real cells only when accepted.
        if (req_fire || halo) begin
          fm_step = 1'b1;
          if (fm_last) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (outstanding == '0 && count == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      fm_dim_q   <= '0;
      wt_base_q  <= '0;
      ifm_base_q <= '0;
      wt_k       <= '0;
      y          <= '0;
      x          <= '0;
      m          <= '0;
      n          <= '0;
    end else begin
      state <= state_n;
      if (clr_cnt) begin
        fm_dim_q   <= fm_dim;
        wt_base_q  <= wt_base_addr;
        ifm_base_q <= ifm_base_addr;
        wt_k       <= '0;
        y          <= '0;
        x          <= '0;
        m          <= '0;
        n          <= '0;
      end else if (wt_step) begin
        wt_k <= wt_k + KW'(1);
      end else if (fm_step) begin
        if (n == MW'(WT_DIM - 1)) begin
          n <= '0;
          if (m == MW'(WT_DIM - 1)) begin
            m <= '0;
            if (x == fm_dim_q - 32'd1) begin
              x <= '0;
              y <= y + 32'd1;
            end else begin
              x <= x + 32'd1;
            end
          end else begin
            m <= m + MW'(1);
          end
        end else begin
          n <= n + MW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      case ({req_fire, push})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the read side is gated by count.
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= resp_data;
  end

endmodule

// File: tb/tb_conv2d_read_fetcher.sv
// Directed bench for conv2d_read_fetcher: a list-based golden model of the request
// stream plus a latency-configurable memory, checked every cycle on the falling edge.
module tb_conv2d_read_fetcher;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WD = 3;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst, start, idle;
  logic [31:0]   fm_dim;
  logic [AW-1:0] wt_base_addr, ifm_base_addr, req_addr;
  logic          req_valid, req_ready;
  logic [DW-1:0] resp_data, rdata;
  logic          resp_valid, rdata_valid, rdata_ready;

  conv2d_read_fetcher #(.AWIDTH(AW), .DWIDTH(DW), .WT_DIM(WD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .start(start), .idle(idle), .fm_dim(fm_dim),
    .wt_base_addr(wt_base_addr), .ifm_base_addr(ifm_base_addr),
    .req_addr(req_addr), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid),
    .rdata(rdata), .rdata_valid(rdata_valid), .rdata_ready(rdata_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] exp_req[$];
  int  ri = 0, oi = 0;
  int  m_out = 0, m_buf = 0;
  int  mem_lat = 1;
  bit  rr_rand = 1'b0, rd_rand = 1'b0, rd_hold = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  // Golden request list: all weights, then every in-bounds cell of each window.
  task automatic build_model(input int fm, input logic [AW-1:0] wb, input logic [AW-1:0] ib);
    exp_req.delete();
    for (int k = 0; k < WD * WD; k++) exp_req.push_back(wb + AW'(k));
    for (int oy = 0; oy < fm; oy++)
      for (int ox = 0; ox < fm; ox++)
        for (int wy = 0; wy < WD; wy++)
          for (int wx = 0; wx < WD; wx++) begin
            int py, px;
            py = oy - WD / 2 + wy;
            px = ox - WD / 2 + wx;
            if (py >= 0 && px >= 0 && py < fm && px < fm)
              exp_req.push_back(ib + AW'(py * fm + px));
          end
  endtask

  // Handshake drivers for req_ready and rdata_ready.
  initial begin
    req_ready   = 1'b1;
    rdata_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      req_ready   = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      rdata_ready = rd_rand ? 1'($urandom_range(0, 1)) : rd_hold;
    end
  end

  // In-order memory with fixed latency; flushed by reset.
  typedef struct { logic [AW-1:0] a; int due; } mreq_t;
  mreq_t mq[$];
  int    cyc = 0;
  initial begin
    logic          f, rv, r;
    logic [AW-1:0] a;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      f  = req_valid && req_ready;
      a  = req_addr;
      rv = resp_valid;
      r  = rst;
      @(posedge clk);
      #1;
      if (r) mq.delete();
      else begin
        if (rv) void'(mq.pop_front());
        if (f)  mq.push_back('{a, cyc + mem_lat});
      end
      cyc++;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = mem_fn(mq[0].a);
      end else begin
        resp_valid = 1'b0;
        resp_data  = '0;
      end
    end
  end

  // Per-cycle compare against the golden list and occupancy model.
  initial begin
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;
    bit            fire, push, pop;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_out = 0;
        m_buf = 0;
        prev_stall = 1'b0;
      end else begin
        fire = req_valid && req_ready;
        push = resp_valid;
        pop  = rdata_valid && rdata_ready;
        if (idle && start) begin
          ri = 0;
          oi = 0;
        end
        chk("rdata_valid_vs_model", rdata_valid, m_buf != 0);
        if (req_valid) chk("credit", (m_out + m_buf) < FD, 1);
        chk("no_overflow", m_buf <= FD, 1);
        if (prev_stall) begin
          chk("stall_valid", req_valid, 1);
          chk("stall_addr", req_addr, prev_addr);
        end
        if (fire) begin
          if (ri < exp_req.size()) chk("req_addr", req_addr, exp_req[ri]);
          else chk("extra_req", ri, exp_req.size());
          ri++;
        end
        if (pop) begin
          if (oi < exp_req.size()) chk("rdata", rdata, mem_fn(exp_req[oi]));
          else chk("extra_word", oi, exp_req.size());
          oi++;
        end
        prev_stall = req_valid && !req_ready;
        prev_addr  = req_addr;
        m_out = m_out + int'(fire) - int'(push);
        m_buf = m_buf + int'(push) - int'(pop);
      end
    end
  end

  task automatic start_job(input int fm, input logic [AW-1:0] wb, input logic [AW-1:0] ib,
                           input int lat);
    build_model(fm, wb, ib);
    mem_lat       = lat;
    fm_dim        = 32'(fm);
    wt_base_addr  = wb;
    ifm_base_addr = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("start_idle_low", idle, 0);
    chk("start_req_valid", req_valid, 1);
    chk("start_req_addr", req_addr, wb);
  endtask

  task automatic finish_job();
    int n = 0;
    while (!idle && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", idle, 1);
    chk("req_count", ri, exp_req.size());
    chk("out_count", oi, exp_req.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    fm_dim = '0;
    wt_base_addr = '0;
    ifm_base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_idle", idle, 1);
    chk("reset_req_valid", req_valid, 0);
    chk("reset_req_addr", req_addr, 0);
    chk("reset_rdata_valid", rdata_valid, 0);
    chk("reset_rdata", rdata, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // fm_dim = 1: nine weights then only the centre pixel.
    start_job(1, 32'h100, 32'h200, 1);
    chk("model_fm1_size", exp_req.size(), 10);
    chk("model_fm1_last_wt", exp_req[8], 32'h108);
    chk("model_fm1_ifm", exp_req[9], 32'h200);
    finish_job();

    // fm_dim = 0: weights only.
    start_job(0, 32'h40, 32'h800, 1);
    chk("model_fm0_size", exp_req.size(), 9);
    finish_job();

    // fm_dim = 3: first window skips the top row and left column.
    start_job(3, 32'h100, 32'h200, 1);
    chk("model_fm3_size", exp_req.size(), 58);
    chk("model_fm3_w0", exp_req[9],  32'h200);
    chk("model_fm3_w1", exp_req[10], 32'h201);
    chk("model_fm3_w2", exp_req[11], 32'h203);
    chk("model_fm3_w3", exp_req[12], 32'h204);
    finish_job();

    // fm_dim = 2 with random request and output back-pressure.
    rr_rand = 1'b1;
    rd_rand = 1'b1;
    start_job(2, 32'h3000, 32'h5000, 2);
    chk("model_fm2_size", exp_req.size(), 25);
    finish_job();
    rr_rand = 1'b0;
    rd_rand = 1'b0;

    // Output blocked for 20 cycles with a 3-cycle memory: credits must cap at FD.
    rd_hold = 1'b0;
    @(posedge clk);
    #1;
    start_job(3, 32'h100, 32'h200, 3);
    repeat (20) @(posedge clk);
    #1;
    chk("blocked_buffered", m_buf, FD);
    chk("blocked_outstanding", m_out, 0);
    chk("blocked_req_valid", req_valid, 0);
    chk("blocked_rdata_valid", rdata_valid, 1);
    rd_hold = 1'b1;
    finish_job();

    // Reset in the middle of the IFM phase, then a complete fresh job.
    start_job(3, 32'h100, 32'h200, 3);
    repeat (25) @(posedge clk);
    #1;
    chk("midjob_busy", idle, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_idle", idle, 1);
    chk("midrst_rdata_valid", rdata_valid, 0);
    chk("midrst_req_valid", req_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    start_job(3, 32'h100, 32'h200, 1);
    finish_job();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv2d_read_fetcher.md
# conv2d_read_fetcher

Read-side address generator and response buffer for the conv2D accelerator. It sits between the DMem read port and the conv2D compute unit. It issues, in order, the WT_DIM×WT_DIM weight words followed by every non-halo IFM word of every sliding window in row-major OFM order. It buffers the returned words in a credit-protected FIFO and presents them on a valid/ready stream matching the compute unit's `rdata` interface. Halo cells are never fetched; the compute unit synthesizes them itself.

## Interface
- `AWIDTH`, 32, word-address width.
- `DWIDTH`, 32, data width.
- `WT_DIM`, 3, weight matrix dimension (odd, ≥1).
- `FIFO_DEPTH`, 4, response buffer entries (power of two, ≥2).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a job when idle; ignored otherwise.
- `idle`  out  1  high when no job is in progress.
- `fm_dim`  in  32  IFM/OFM dimension; sampled at accepted `start`.
- `wt_base_addr`  in  AWIDTH  word address of weight[0][0]; sampled at `start`.
- `ifm_base_addr`  in  AWIDTH  word address of IFM(0,0); sampled at `start`.
- `req_addr`  out  AWIDTH  DMem read word address.
- `req_valid`  out  1  read request valid.
- `req_ready`  in  1  DMem accepts request.
- `resp_data`  in  DWIDTH  DMem read data.
- `resp_valid`  in  1  response valid. Responses arrive in request order, ≥1 cycle after acceptance, and cannot be stalled.
- `rdata`  out  DWIDTH  head-of-FIFO word to the compute unit.
- `rdata_valid`  out  1  FIFO non-empty.
- `rdata_ready`  in  1  compute unit pops the head.

## Operation
- States: IDLE, FETCH_WT, FETCH_FM, DRAIN.
- IDLE:
  - `start` latches `fm_dim` and both base addresses.
  - Clears all counters and goes to FETCH_WT.
- FETCH_WT:
  - Request k (k = 0..WT_DIM²−1) uses address `wt_base_addr + k`.
  - After the last weight request fires, go to FETCH_FM.
  - If `fm_dim == 0`, go to DRAIN instead.
- FETCH_FM:
  - Nested counters, outer to inner: y, x, m, n. The innermost counter n advances fastest.
  - idx = x − WT_DIM/2 + n and idy = y − WT_DIM/2 + m, both signed 32-bit.
  - Halo: idx<0, idy<0, idx≥fm_dim or idy≥fm_dim.
  - Non-halo position: assert `req_valid` with `req_addr = ifm_base_addr + idy*fm_dim + idx`, truncated to AWIDTH. Advance only when the request fires.
  - Halo position: skip in one cycle with no request.
  - After (y,x,m,n) = (fm_dim−1, fm_dim−1, WT_DIM−1, WT_DIM−1) completes, go to DRAIN.
- DRAIN: wait until outstanding == 0 and FIFO empty, then go to IDLE.
- Credit rule:
  - outstanding = requests accepted minus responses received.
  - `req_valid` may be high only when outstanding + fifo_count < FIFO_DEPTH.
  - Every response is therefore guaranteed a slot; the FIFO never overflows.
- FIFO behaviour:
  - Push on `resp_valid`; pop on `rdata_valid & rdata_ready`.
  - Simultaneous push and pop leaves the count unchanged and is legal when full.
- Counter resolution:
  - outstanding and count are sized to hold the value FIFO_DEPTH.
  - Request acceptance and response arrival in the same cycle leave outstanding unchanged.

## Timing
- Reset values:
  - `idle` = 1.
  - `req_valid` = 0, `req_addr` = 0.
  - `rdata_valid` = 0, `rdata` = 0.
  - FIFO empty; all counters 0.
- Start latency:
  - `start` accepted in cycle 0.
  - `idle` drops and the state becomes FETCH_WT in cycle 1.
  - `req_valid` = 1 with `req_addr = wt_base_addr` in cycle 1.
- With `req_ready` held at 1 and no credit stall, one request is issued per cycle. Each halo skip costs one bubble cycle.
- `rdata`/`rdata_valid` are driven from registered FIFO state. A response pushed in cycle t is visible at the head in cycle t+1.
- `req_addr` and `req_valid` are stable while `req_valid & !req_ready`.
- `idle` rises in the cycle after DRAIN sees outstanding == 0 and FIFO empty.
- Reset mid-job:
  - Returns to IDLE and flushes the FIFO next cycle.
  - Responses still in flight are dropped. Synchronizing DMem with `rst` is the system's responsibility.

## Test plan
- Reset → `idle`=1, `req_valid`=0, `rdata_valid`=0. Start with fm_dim=1, wt_base=0x100, ifm_base=0x200, 1-cycle memory, `rdata_ready`=1 → requests 0x100..0x108, then 0x200 only; 10 words out in order; `idle` returns high.
- fm_dim=3 → exactly 58 requests (9 weights + 49 IFM). The first IFM window (y=0, x=0) fetches 0x200, 0x201, 0x203, 0x204 in that order.
- fm_dim=2 with `req_ready` randomly deasserted → 25 requests. Address held stable during stalls; output sequence matches the golden model.
- `rdata_ready`=0 for 20 cycles with a 3-cycle memory → at most FIFO_DEPTH requests outstanding-plus-buffered; no overflow; no word lost after release.
- Simultaneous push and pop at FIFO full, and simultaneous issue and response → counts unchanged, data order preserved.
- `rst` asserted mid-FETCH_FM → next cycle `idle`=1, `rdata_valid`=0. A fresh `start` then reproduces the full correct sequence.
